// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_DRAIN = 3'd3,
    FETCH_HOLD  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch FSM: one outstanding imem request, word latched and offered to decode; 3-cycle best-case cadence.
// Decode backpressure holds the word and stalls further requests; redirects drain in-flight responses.
module fetch_sequencer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_dec_valid,
  output logic [31:0]     o_dec_instr,
  output logic [XLEN-1:0] o_dec_pc,
  input  logic            i_dec_ready
);
  import fetch_sequencer_pkg::*;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_PC_W = RESET_PC & ALIGN_MASK;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] dpc_q, dpc_d;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = i_redirect_pc & ALIGN_MASK;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC_W;
      instr_q <= NOP_INSTR;
      dpc_q   <= RESET_PC_W;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (i_redirect) begin
          pc_d    = redirect_tgt;
          state_d = i_imem_gnt ? FETCH_DRAIN : FETCH_REQ;
        end else if (i_imem_gnt) begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (i_redirect) begin
          pc_d    = redirect_tgt;
          state_d = i_imem_rvalid ? FETCH_REQ : FETCH_DRAIN;
        end else if (i_imem_rvalid) begin
          instr_d = i_imem_rdata;
          dpc_d   = pc_q;
          state_d = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (i_redirect) begin
          pc_d    = redirect_tgt;
          state_d = FETCH_REQ;
        end else if (i_dec_ready) begin
          pc_d    = pc_q + XLEN'(WORD_BYTES);
          state_d = FETCH_REQ;
        end
      end
      FETCH_DRAIN: begin
        // A redirect here only retargets pc; the stale response must still be swallowed.
        if (i_redirect) pc_d = redirect_tgt;
        if (i_imem_rvalid) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  assign o_imem_req  = (state_q == FETCH_REQ);
  assign o_imem_addr = pc_q;
  assign o_dec_valid = (state_q == FETCH_HOLD);
  assign o_dec_instr = instr_q;
  assign o_dec_pc    = dpc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench: two instances (RESET_PC 0 and 0xFFFFFFFC) share stimulus and are checked each cycle against a transaction-level model.
module tb_fetch_sequencer;

  localparam logic [31:0] RP0 = 32'h00000000;
  localparam logic [31:0] RP1 = 32'hFFFFFFFC;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, gnt, rvalid, redir, ready;
  logic [31:0] rdata, rpc;

  logic        req_o   [2];
  logic [31:0] addr_o  [2];
  logic        valid_o [2];
  logic [31:0] instr_o [2];
  logic [31:0] dpc_o   [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: request pending/response owed/word held, rather than explicit FSM states.
  bit          m_started, m_out, m_drop, m_have;
  logic [31:0] m_pc [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_dpc [2];

  always #5 clk = ~clk;

  fetch_sequencer #(.XLEN(32), .RESET_PC(RP0)) u0 (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(req_o[0]), .o_imem_addr(addr_o[0]),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redir), .i_redirect_pc(rpc),
    .o_dec_valid(valid_o[0]), .o_dec_instr(instr_o[0]), .o_dec_pc(dpc_o[0]),
    .i_dec_ready(ready)
  );

  fetch_sequencer #(.XLEN(32), .RESET_PC(RP1)) u1 (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(req_o[1]), .o_imem_addr(addr_o[1]),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redir), .i_redirect_pc(rpc),
    .o_dec_valid(valid_o[1]), .o_dec_instr(instr_o[1]), .o_dec_pc(dpc_o[1]),
    .i_dec_ready(ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req();
    return m_started && !m_out && !m_have;
  endfunction

  task automatic model_step();
    bit req_now;
    if (rst) begin
      m_started = 0; m_out = 0; m_drop = 0; m_have = 0;
      for (int i = 0; i < 2; i++) begin
        m_pc[i]    = (i == 0) ? RP0 : RP1;
        m_instr[i] = NOP;
        m_dpc[i]   = m_pc[i];
      end
    end else if (!m_started) begin
      m_started = 1;
    end else begin
      req_now = !m_out && !m_have;
      if (redir) begin
        if (req_now) begin
          if (gnt) begin m_out = 1; m_drop = 1; end
        end else if (m_out) begin
          if (rvalid) begin m_out = 0; m_drop = 0; end
          else m_drop = 1;
        end else begin
          m_have = 0;
        end
        for (int i = 0; i < 2; i++) m_pc[i] = {rpc[31:2], 2'b00};
      end else if (req_now) begin
        if (gnt) m_out = 1;
      end else if (m_out) begin
        if (rvalid) begin
          m_out = 0;
          if (m_drop) m_drop = 0;
          else begin
            m_have = 1;
            for (int i = 0; i < 2; i++) begin
              m_instr[i] = rdata;
              m_dpc[i]   = m_pc[i];
            end
          end
        end
      end else if (m_have && ready) begin
        m_have = 0;
        for (int i = 0; i < 2; i++) m_pc[i] = m_pc[i] + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    if (!chk_en) return;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("req_u%0d", i),   {31'b0, req_o[i]},   {31'b0, exp_req()});
      chk($sformatf("valid_u%0d", i), {31'b0, valid_o[i]}, {31'b0, m_have});
      chk($sformatf("addr_u%0d", i),  addr_o[i],  m_pc[i]);
      chk($sformatf("instr_u%0d", i), instr_o[i], m_instr[i]);
      chk($sformatf("dpc_u%0d", i),   dpc_o[i],   m_dpc[i]);
    end
  endtask

  task automatic tick();
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Memory responder driven from the model: grants only to a live request, responds only when owed.
  task automatic run1(input bit gnt_en, input bit rv_en);
    gnt    = gnt_en && exp_req();
    rvalid = rv_en && m_out;
    rdata  = $urandom;
    tick();
    redir = 0;
  endtask

  initial begin
    rst = 1; gnt = 0; rvalid = 0; rdata = '0; redir = 0; rpc = '0; ready = 0;
    @(posedge clk);
    model_step();
    #1;
    chk_en = 1;

    // Reset values and streaming cadence, including pc wrap on u1.
    chk("rst_instr", instr_o[0], NOP);
    chk("rst_dpc_u1", dpc_o[1], RP1);
    rst = 0; ready = 1;
    chk("idle_req", {31'b0, req_o[0]}, 32'd0);
    run1(1, 1);
    chk("first_req", {31'b0, req_o[0]}, 32'd1);
    chk("first_addr_u1", addr_o[1], 32'hFFFFFFFC);
    repeat (3) run1(1, 1);
    chk("addr4_u0", addr_o[0], 32'h4);
    chk("wrap_u1", addr_o[1], 32'h0);
    repeat (3) run1(1, 1);
    chk("addr8_u0", addr_o[0], 32'h8);

    // Decode backpressure in HOLD.
    ready = 0;
    for (int k = 0; k < 10 && !m_have; k++) run1(1, 1);
    repeat (5) run1(1, 1);
    chk("bp_valid", {31'b0, valid_o[0]}, 32'd1);
    ready = 1;
    run1(1, 1);

    // Redirect coinciding with grant: drain and drop the in-flight word.
    for (int k = 0; k < 10 && !exp_req(); k++) run1(1, 1);
    gnt = 1; rvalid = 0; redir = 1; rpc = 32'h103;
    tick();
    redir = 0; gnt = 0;
    tick();
    rvalid = 1; rdata = 32'hDEADBEEF;
    tick();
    rvalid = 0;
    chk("drain_req", {31'b0, req_o[0]}, 32'd1);
    chk("drain_addr", addr_o[0], 32'h100);

    // Redirect in HOLD together with decode accept.
    ready = 0;
    for (int k = 0; k < 10 && !m_have; k++) run1(1, 1);
    ready = 1; redir = 1; rpc = 32'h200;
    tick();
    redir = 0;
    chk("hold_redir_valid", {31'b0, valid_o[0]}, 32'd0);
    chk("hold_redir_addr", addr_o[0], 32'h200);

    // Late grant with a redirect while the request is still pending.
    gnt = 0;
    tick();
    redir = 1; rpc = 32'h40;
    tick();
    redir = 0;
    chk("late_addr", addr_o[0], 32'h40);
    tick();
    gnt = 1;
    tick();
    gnt = 0;
    chk("late_wait_req", {31'b0, req_o[0]}, 32'd0);
    rvalid = 1; rdata = 32'h12345678;
    tick();
    rvalid = 0;
    chk("late_dpc", dpc_o[0], 32'h40);
    chk("late_instr", instr_o[0], 32'h12345678);
    run1(1, 1);

    // Reset while a response is owed.
    for (int k = 0; k < 10 && !(m_out && !m_drop); k++) run1(1, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_wait_req", {31'b0, req_o[0]}, 32'd0);
    chk("rst_wait_addr_u1", addr_o[1], RP1);
    tick();
    chk("rst_wait_req2", {31'b0, req_o[0]}, 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 11) == 0);
      rpc   = $urandom;
      rst   = ($urandom_range(0, 299) == 0);
      gnt    = ($urandom_range(0, 1) == 1) && exp_req();
      rvalid = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      rdata  = $urandom;
      tick();
    end
    rst = 0; redir = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
